// File: rtl/pong_game_ctl.sv
// Pong game-flow sequencer: gates ball motion, detects paddle hits and misses,
// keeps score and declares a winner. Single clock domain (pclk).
module pong_game_ctl #(
   parameter int BALL_DIAMETER = 16,
   parameter int PADDLE_H      = 64,
   parameter int L_EDGE        = 24,
   parameter int R_EDGE        = 982,
   parameter int POINT_FRAMES  = 60,
   parameter int WIN_SCORE     = 9
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        mouse_left,
   input  logic [11:0] ball_xpos,
   input  logic [11:0] ball_ypos,
   input  logic [11:0] pad_l_ypos,
   input  logic [11:0] pad_r_ypos,
   output logic        ball_run,
   output logic        bounce_l,
   output logic        bounce_r,
   output logic [3:0]  score_l,
   output logic [3:0]  score_r,
   output logic [1:0]  winner,
   output logic [1:0]  game_state
);

   typedef enum logic [1:0] {
      SERVE = 2'b00,
      PLAY  = 2'b01,
      POINT = 2'b10,
      OVER  = 2'b11
   } state_t;

   localparam int CW = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;

   state_t          state_q;
   logic            mouse_prev_q;
   logic [11:0]     x_prev_q;
   logic            lock_l_q, lock_r_q;
   logic [CW-1:0]   cnt_q;
   logic            ball_run_q, bounce_l_q, bounce_r_q;
   logic [3:0]      score_l_q, score_r_q;
   logic [1:0]      winner_q;

   logic press, moving_left, moving_right;
   logic overlap_l, overlap_r, zone_l, zone_r;

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s == 4'hF) ? s : s + 4'd1;
   endfunction

   // Vertical overlap is evaluated in 13 bits so paddle/ball bottoms near 4095 cannot wrap.
   always_comb begin
      press        = mouse_left & ~mouse_prev_q;
      moving_left  = ball_xpos < x_prev_q;
      moving_right = ball_xpos > x_prev_q;
      overlap_l    = ({1'b0, ball_ypos} + 13'(BALL_DIAMETER) > {1'b0, pad_l_ypos}) &&
                     ({1'b0, ball_ypos} < {1'b0, pad_l_ypos} + 13'(PADDLE_H));
      overlap_r    = ({1'b0, ball_ypos} + 13'(BALL_DIAMETER) > {1'b0, pad_r_ypos}) &&
                     ({1'b0, ball_ypos} < {1'b0, pad_r_ypos} + 13'(PADDLE_H));
      zone_l       = (ball_xpos <= 12'(L_EDGE)) && moving_left  && !lock_l_q;
      zone_r       = (ball_xpos >= 12'(R_EDGE)) && moving_right && !lock_r_q;
   end

   // NOTE: sequential state uses non-blocking assignments only; later statements in this block deliberately override earlier defaults.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q      <= SERVE;
         mouse_prev_q <= 1'b0;
         x_prev_q     <= '0;
         lock_l_q     <= 1'b0;
         lock_r_q     <= 1'b0;
         cnt_q        <= '0;
         ball_run_q   <= 1'b0;
         bounce_l_q   <= 1'b0;
         bounce_r_q   <= 1'b0;
         score_l_q    <= '0;
         score_r_q    <= '0;
         winner_q     <= '0;
      end else begin
         mouse_prev_q <= mouse_left;
         bounce_l_q   <= 1'b0;
         bounce_r_q   <= 1'b0;
         if (frame_tick) x_prev_q <= ball_xpos;
         if (ball_xpos > 12'(L_EDGE)) lock_l_q <= 1'b0;
         if (ball_xpos < 12'(R_EDGE)) lock_r_q <= 1'b0;

         case (state_q)
            SERVE: begin
               if (press) begin
                  state_q    <= PLAY;
                  ball_run_q <= 1'b1;
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  if (zone_l) begin
                     if (overlap_l) begin
                        bounce_l_q <= 1'b1;
                        lock_l_q   <= 1'b1;
                     end else begin
                        score_r_q  <= sat_inc(score_r_q);
                        state_q    <= POINT;
                        ball_run_q <= 1'b0;
                        cnt_q      <= '0;
                     end
                  end else if (zone_r) begin
                     if (overlap_r) begin
                        bounce_r_q <= 1'b1;
                        lock_r_q   <= 1'b1;
                     end else begin
                        score_l_q  <= sat_inc(score_l_q);
                        state_q    <= POINT;
                        ball_run_q <= 1'b0;
                        cnt_q      <= '0;
                     end
                  end
               end
            end
            POINT: begin
               if (frame_tick) begin
                  if (cnt_q == CW'(POINT_FRAMES - 1)) begin
                     lock_l_q <= 1'b0;
                     lock_r_q <= 1'b0;
                     if (score_l_q == 4'(WIN_SCORE)) begin
                        winner_q <= 2'b01;
                        state_q  <= OVER;
                     end else if (score_r_q == 4'(WIN_SCORE)) begin
                        winner_q <= 2'b10;
                        state_q  <= OVER;
                     end else begin
                        state_q  <= SERVE;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            OVER: begin
               if (press) begin
                  score_l_q <= '0;
                  score_r_q <= '0;
                  winner_q  <= '0;
                  state_q   <= SERVE;
               end
            end
            default: state_q <= SERVE;
         endcase
      end
   end

   assign ball_run   = ball_run_q;
   assign bounce_l   = bounce_l_q;
   assign bounce_r   = bounce_r_q;
   assign score_l    = score_l_q;
   assign score_r    = score_r_q;
   assign winner     = winner_q;
   assign game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctl.sv
// Self-checking bench for pong_game_ctl: directed game scenarios followed by
// randomized play, all outputs compared every cycle against a rule-level model.
module tb_pong_game_ctl;

   localparam int BD   = 16;
   localparam int PH   = 64;
   localparam int LE   = 24;
   localparam int RE   = 982;
   localparam int PF   = 60;
   localparam int WIN  = 9;

   localparam int G_SERVE = 0;
   localparam int G_PLAY  = 1;
   localparam int G_POINT = 2;
   localparam int G_OVER  = 3;

   logic        pclk, rst, frame_tick, mouse_left;
   logic [11:0] ball_xpos, ball_ypos, pad_l_ypos, pad_r_ypos;
   logic        ball_run, bounce_l, bounce_r;
   logic [3:0]  score_l, score_r;
   logic [1:0]  winner, game_state;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: game phase, scores and bookkeeping as plain integers.
   int m_phase, m_mprev, m_xprev, m_lock_l, m_lock_r, m_wait;
   int m_sl, m_sr, m_win, m_run, m_bl, m_br;

   pong_game_ctl #(
      .BALL_DIAMETER(BD), .PADDLE_H(PH), .L_EDGE(LE), .R_EDGE(RE),
      .POINT_FRAMES(PF), .WIN_SCORE(WIN)
   ) dut (
      .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .mouse_left(mouse_left),
      .ball_xpos(ball_xpos), .ball_ypos(ball_ypos),
      .pad_l_ypos(pad_l_ypos), .pad_r_ypos(pad_r_ypos),
      .ball_run(ball_run), .bounce_l(bounce_l), .bounce_r(bounce_r),
      .score_l(score_l), .score_r(score_r), .winner(winner), .game_state(game_state)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = G_SERVE; m_mprev = 0; m_xprev = 0; m_lock_l = 0; m_lock_r = 0;
      m_wait = 0; m_sl = 0; m_sr = 0; m_win = 0; m_run = 0; m_bl = 0; m_br = 0;
   endtask

   // Applies the game rules to the inputs present at the coming clock edge.
   task automatic model_step();
      int bx, by, pl, pr;
      bit press, ml, mr, ovl, ovr, lz, rz;
      bx = int'(ball_xpos); by = int'(ball_ypos);
      pl = int'(pad_l_ypos); pr = int'(pad_r_ypos);
      press = mouse_left && (m_mprev == 0);
      ml  = bx < m_xprev;
      mr  = bx > m_xprev;
      ovl = (by + BD > pl) && (by < pl + PH);
      ovr = (by + BD > pr) && (by < pr + PH);
      lz  = (bx <= LE) && ml && (m_lock_l == 0);
      rz  = (bx >= RE) && mr && (m_lock_r == 0);
      m_bl = 0; m_br = 0;
      if (bx > LE) m_lock_l = 0;
      if (bx < RE) m_lock_r = 0;
      case (m_phase)
         G_SERVE: if (press) begin m_phase = G_PLAY; m_run = 1; end
         G_PLAY: if (frame_tick) begin
            if (lz) begin
               if (ovl) begin m_bl = 1; m_lock_l = 1; end
               else begin m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_phase = G_POINT; m_run = 0; m_wait = PF; end
            end else if (rz) begin
               if (ovr) begin m_br = 1; m_lock_r = 1; end
               else begin m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_phase = G_POINT; m_run = 0; m_wait = PF; end
            end
         end
         G_POINT: if (frame_tick) begin
            m_wait--;
            if (m_wait == 0) begin
               m_lock_l = 0; m_lock_r = 0;
               if (m_sl == WIN)      begin m_win = 1; m_phase = G_OVER; end
               else if (m_sr == WIN) begin m_win = 2; m_phase = G_OVER; end
               else m_phase = G_SERVE;
            end
         end
         default: if (press) begin m_sl = 0; m_sr = 0; m_win = 0; m_phase = G_SERVE; end
      endcase
      m_mprev = mouse_left ? 1 : 0;
      if (frame_tick) m_xprev = bx;
   endtask

   task automatic compare_all();
      check("ball_run",   ball_run,   m_run);
      check("bounce_l",   bounce_l,   m_bl);
      check("bounce_r",   bounce_r,   m_br);
      check("score_l",    score_l,    m_sl);
      check("score_r",    score_r,    m_sr);
      check("winner",     winner,     m_win);
      check("game_state", game_state, m_phase);
   endtask

   task automatic step(input bit tick, input bit mouse);
      frame_tick = tick;
      mouse_left = mouse;
      model_step();
      @(posedge pclk);
      #1;
      compare_all();
   endtask

   task automatic tick_at(input int x);
      ball_xpos = 12'(x);
      step(1'b1, 1'b0);
   endtask

   task automatic wait_point();
      repeat (PF) step(1'b1, 1'b0);
   endtask

   task automatic serve();
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
   endtask

   task automatic miss_right();
      ball_ypos  = 12'd500;
      pad_r_ypos = 12'd0;
      tick_at(975);
      tick_at(983);
   endtask

   task automatic probe_l(input int y, input bit hit);
      pad_l_ypos = 12'd200;
      ball_ypos  = 12'(y);
      tick_at(40);
      tick_at(23);
      check($sformatf("overlap_y%0d", y), bounce_l, hit);
      if (!hit) begin
         wait_point();
         serve();
      end
   endtask

   initial begin
      int trans;
      logic [1:0] prev_gs;

      rst = 1'b1; frame_tick = 1'b0; mouse_left = 1'b0;
      ball_xpos = '0; ball_ypos = '0; pad_l_ypos = '0; pad_r_ypos = '0;
      model_reset();
      #2;
      compare_all();
      #6 rst = 1'b0;

      // Held button in SERVE gives exactly one start.
      trans   = 0;
      prev_gs = game_state;
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b1);
         if (i == 0) check("run_after_press", ball_run, 1);
         if (game_state != prev_gs) trans++;
         prev_gs = game_state;
      end
      check("hold_transitions", trans, 1);
      step(1'b0, 1'b0);

      // Left paddle hit, then no repeat while inside the zone.
      ball_ypos = 12'd200; pad_l_ypos = 12'd180;
      tick_at(30);
      tick_at(23);
      check("bounce_l_hit", bounce_l, 1);
      step(1'b0, 1'b0);
      check("bounce_l_width", bounce_l, 0);
      tick_at(22);
      check("bounce_l_no_repeat", bounce_l, 0);
      check("still_play", game_state, G_PLAY);

      // Left miss and the POINT pause.
      ball_ypos = 12'd300;
      tick_at(40);
      tick_at(23);
      check("miss_score_r", score_r, 1);
      check("miss_state", game_state, G_POINT);
      check("miss_run", ball_run, 0);
      repeat (PF - 1) step(1'b1, 1'b0);
      check("point_hold", game_state, G_POINT);
      step(1'b1, 1'b0);
      check("point_done", game_state, G_SERVE);
      serve();

      // Overlap boundaries against a paddle at y = 200.
      probe_l(184, 1'b0);
      probe_l(185, 1'b1);
      probe_l(263, 1'b1);
      probe_l(264, 1'b0);

      // Left player wins the game.
      repeat (WIN - 1) begin
         miss_right();
         wait_point();
         serve();
      end
      miss_right();
      check("score_l_win", score_l, WIN);
      wait_point();
      check("over_state", game_state, G_OVER);
      check("over_winner", winner, 1);
      repeat (5) step(1'b1, 1'b0);
      check("over_hold_score", score_l, WIN);
      step(1'b0, 1'b1);
      check("restart_score_l", score_l, 0);
      check("restart_score_r", score_r, 0);
      check("restart_winner", winner, 0);
      check("restart_state", game_state, G_SERVE);
      step(1'b0, 1'b0);

      // Asynchronous reset in PLAY with a non-zero score.
      serve();
      repeat (3) begin
         miss_right();
         wait_point();
         serve();
      end
      check("pre_reset_score_l", score_l, 3);
      check("pre_reset_state", game_state, G_PLAY);
      #3 rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      #1 rst = 1'b0;

      // Randomized play.
      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 3))
            0:       ball_xpos = 12'($urandom_range(0, 40));
            1:       ball_xpos = 12'($urandom_range(960, 1023));
            default: ball_xpos = 12'($urandom_range(0, 1023));
         endcase
         ball_ypos  = 12'($urandom_range(0, 479));
         pad_l_ypos = 12'($urandom_range(0, 479));
         pad_r_ypos = 12'($urandom_range(0, 479));
         step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pong_game_ctl.md
Name: pong_game_ctl

Overview:
- Game-flow sequencer for the Pong ball datapath.
- Gates ball motion through ball_run (the ball controller holds its ball at the serve position while ball_run is low).
- Detects paddle contact and misses from ball/paddle positions, issues bounce pulses, keeps score and declares a winner.
- Sits between the mouse/paddle logic and the ball controller, in the pclk domain.

Parameters:
BALL_DIAMETER, 16, ball size in pixels
PADDLE_H, 64, paddle height in pixels
L_EDGE, 24, x at or below which the ball is in the left paddle zone
R_EDGE, 982, x at or above which the ball is in the right paddle zone
POINT_FRAMES, 60, frame ticks spent in POINT before continuing
WIN_SCORE, 9, score that ends the game (max 15)

Ports:
pclk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame
mouse_left  in  1  level, serve/restart button
ball_xpos  in  12  ball top-left x
ball_ypos  in  12  ball top-left y
pad_l_ypos  in  12  left paddle top y
pad_r_ypos  in  12  right paddle top y
ball_run  out  1  high = ball may move
bounce_l  out  1  one-cycle pulse, left paddle hit
bounce_r  out  1  one-cycle pulse, right paddle hit
score_l  out  4  left player score
score_r  out  4  right player score
winner  out  2  00 none, 01 left, 10 right
game_state  out  2  current state encoding

Behaviour:
- Clock and reset: one clock, pclk. rst is asynchronous and active-high.
- All outputs are registered. Reset value of every output and internal register is 0. State resets to SERVE (00).
- Reset mid-operation: everything returns to the reset values immediately.
- Press detection:
  - press = mouse_left & ~mouse_prev.
  - mouse_prev is registered every cycle and resets to 0.
  - A held button produces exactly one press.
- Direction tracking:
  - x_prev is loaded with ball_xpos on each frame_tick.
  - moving_left = ball_xpos < x_prev; moving_right = ball_xpos > x_prev.
- Overlap rule, with all arithmetic 13-bit unsigned (no wrap):
  - overlap_l = (ball_ypos + BALL_DIAMETER > pad_l_ypos) && (ball_ypos < pad_l_ypos + PADDLE_H).
  - overlap_r is the same with pad_r_ypos.
- States:
  - SERVE (00): ball_run = 0.
    - press -> PLAY on the next edge.
    - ball_run = 1 in the cycle after entry.
  - PLAY (01): ball_run = 1. Evaluated only on frame_tick cycles.
    - Left zone (ball_xpos <= L_EDGE, moving_left, lock_l = 0):
      - overlap_l -> bounce_l = 1 for one cycle, lock_l set.
      - no overlap_l -> score_r + 1, go to POINT.
    - Right zone (ball_xpos >= R_EDGE, moving_right, lock_r = 0): same rule with bounce_r / score_l.
    - lock_l clears when ball_xpos > L_EDGE; lock_r clears when ball_xpos < R_EDGE. This prevents repeated hits while the ball stays in the zone.
    - Both zones true in one tick: the left zone wins and the right zone is ignored.
    - press in PLAY is ignored.
  - POINT (10): ball_run = 0, and the frame counter is cleared on entry.
    - Each frame_tick increments the counter.
    - When the counter reaches POINT_FRAMES - 1 on a tick:
      - a score equal to WIN_SCORE -> OVER, with winner set to 01 or 10;
      - otherwise -> SERVE.
    - Locks are cleared on leaving POINT.
  - OVER (11): ball_run = 0, scores and winner are held.
    - press -> clear scores and winner, go to SERVE.
- Bounce pulses are never asserted outside PLAY. Bounce pulses and a score change never occur in the same cycle.
- Scores saturate at 15.
- The 2-bit state register has all 4 encodings used, so there is no illegal state.

Test Plan:
- Reset during PLAY with score_l = 3 -> all outputs 0 and game_state = 00 on the asynchronous assertion, with no clock needed.
- In SERVE, hold mouse_left high for 100 cycles -> exactly one transition to PLAY, and ball_run = 1 one cycle after the press edge.
- PLAY, ball moving left from x = 30 to x = 23, ball_ypos = 200, pad_l_ypos = 180, frame_tick -> bounce_l pulses once. Next tick at x = 22 -> no second pulse.
- PLAY, ball moving left to x = 23, ball_ypos = 300, pad_l_ypos = 180 -> score_r = 1, game_state = 10, ball_run = 0. After 60 frame_ticks -> game_state = 00.
- score_l = 8, right miss -> score_l = 9. After POINT -> game_state = 11, winner = 01. A later press -> scores 0, winner 00, game_state = 00.
- Overlap boundary with pad_l_ypos = 200:
  - ball_ypos = 184 (ball_ypos + 16 = 200) -> miss.
  - ball_ypos = 185 -> hit.
  - ball_ypos = 263 -> hit.
  - ball_ypos = 264 -> miss.
